// File: rtl/fire_queue_pkg.sv
// Shared game types: sprite direction encoding and the shot-issue FSM states,
// also used by bullet_movement.
package fire_queue_pkg;

   localparam int ORIENT_W = 2;

   typedef enum logic [ORIENT_W-1:0] {
      ORIENT_RIGHT = 2'b00,
      ORIENT_DOWN  = 2'b01,
      ORIENT_LEFT  = 2'b10,
      ORIENT_UP    = 2'b11
   } orientation_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_START,
      ST_IN_FLIGHT
   } issue_state_t;

   // Bits needed for a down-counter that must hold max_val (never below 1).
   function automatic int cnt_width(input int max_val);
      if (max_val < 2) return 1;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/fire_queue_if.sv
// Player-side and bullet-side signals of the fire queue, grouped as one bundle.
interface fire_queue_if
   import fire_queue_pkg::*;
#(
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             btn_fire;
   orientation_t     orientation_in;
   logic             bullet_active;
   logic             fire;
   orientation_t     orientation_out;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             dropped;

   modport master (
      output btn_fire, orientation_in, bullet_active,
      input  fire, orientation_out, count, full, empty, dropped
   );

   modport slave (
      input  btn_fire, orientation_in, bullet_active,
      output fire, orientation_out, count, full, empty, dropped
   );

endinterface

// File: rtl/fire_queue_shot_fifo.sv
// Small synchronous FIFO of queued shot orientations; push is ignored when full
// and pop is ignored when empty, so callers may gate loosely.
module shot_fifo
   import fire_queue_pkg::*;
#(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = ORIENT_W,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else begin
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fire_queue.sv
// Fire-button shot queue: press edge detect, rate-limit cooldown, shot FIFO and
// an issue FSM that launches one bullet at a time into bullet_movement.
module fire_queue
   import fire_queue_pkg::*;
#(
   parameter int DEPTH         = 4,
   parameter int COOLDOWN      = 16,
   parameter int START_TIMEOUT = 4
) (
   input  logic        clk,
   input  logic        reset,
   fire_queue_if.slave bus
);

   // state         | meaning
   // ST_IDLE       | waiting for a queued shot and an idle bullet
   // ST_ISSUE      | head popped and latched, fire pulse is high
   // ST_WAIT_START | waiting for bullet_active, bounded by START_TIMEOUT
   // ST_IN_FLIGHT  | bullet moving, waiting for it to finish

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int CD_W  = cnt_width(COOLDOWN - 1);
   localparam int TO_W  = cnt_width(START_TIMEOUT - 1);
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN - 1);
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(START_TIMEOUT - 1);

   logic                r_arm;
   logic                r_btn_prev;
   logic                r_press;
   orientation_t        r_press_orient;
   logic [CD_W-1:0]     r_cooldown;
   logic                r_dropped;
   logic [TO_W-1:0]     r_timer;
   logic                r_fire;
   orientation_t        r_orient;
   issue_state_t        r_state;
   issue_state_t        w_state_nxt;
   logic                w_press;
   logic                w_cd_zero;
   logic                w_push;
   logic                w_drop;
   logic                w_pop;
   logic                w_fire_nxt;
   logic [ORIENT_W-1:0] w_fifo_rdata;
   logic [CNT_W-1:0]    w_count;
   logic                w_full;
   logic                w_empty;

   // r_arm masks the first cycle after reset so a button held through reset
   // release is seen as already pressed rather than as a new edge.
   assign w_press = r_arm & bus.btn_fire & ~r_btn_prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_arm          <= 1'b0;
         r_btn_prev     <= 1'b0;
         r_press        <= 1'b0;
         r_press_orient <= ORIENT_RIGHT;
      end else begin
         r_arm          <= 1'b1;
         r_btn_prev     <= bus.btn_fire;
         r_press        <= w_press;
         r_press_orient <= bus.orientation_in;
      end
   end

   // Cooldown rejects silently; only a full queue reports a drop.
   assign w_cd_zero = (r_cooldown == '0);
   assign w_push    = r_press & w_cd_zero & ~w_full;
   assign w_drop    = r_press & w_cd_zero & w_full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cooldown <= '0;
         r_dropped  <= 1'b0;
      end else begin
         r_dropped <= w_drop;
         if (w_push)          r_cooldown <= CD_LOAD;
         else if (!w_cd_zero) r_cooldown <= r_cooldown - CD_W'(1);
      end
   end

   shot_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ORIENT_W)
   ) u_shot_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_wdata (r_press_orient),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_fire_nxt  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (!w_empty && !bus.bullet_active) begin
               w_pop       = 1'b1;
               w_fire_nxt  = 1'b1;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_state_nxt = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            if (bus.bullet_active)  w_state_nxt = ST_IN_FLIGHT;
            else if (r_timer == '0) w_state_nxt = ST_IDLE;
         end
         ST_IN_FLIGHT: begin
            if (!bus.bullet_active) w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_fire   <= 1'b0;
         r_orient <= ORIENT_RIGHT;
      end else begin
         r_state <= w_state_nxt;
         r_fire  <= w_fire_nxt;
         if (w_pop) r_orient <= orientation_t'(w_fifo_rdata);
      end
   end

   // Start timeout: loaded while the fire pulse is out, counts WAIT_START cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_timer <= '0;
      end else if (r_state == ST_ISSUE) begin
         r_timer <= TO_LOAD;
      end else if (r_state == ST_WAIT_START && r_timer != '0) begin
         r_timer <= r_timer - TO_W'(1);
      end
   end

   assign bus.fire            = r_fire;
   assign bus.orientation_out = r_orient;
   assign bus.count           = w_count;
   assign bus.full            = w_full;
   assign bus.empty           = w_empty;
   assign bus.dropped         = r_dropped;

endmodule

// File: tb/tb_fire_queue.sv
// Scoreboard bench for fire_queue: stimulus queues expected fire/drop events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_fire_queue;
   import fire_queue_pkg::*;

   typedef struct {
      logic [1:0] orient;
      int         cyc;
   } fire_exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   fire_exp_t fire_q[$];
   int        drop_q[$];

   logic hold;
   logic auto_bullet;
   int   b_len;
   int   b_cnt = 0;
   logic fire_seen = 1'b0;
   logic prev_fire = 1'b0;

   logic [1:0] t2_orients [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
   logic [1:0] t5_orients [4] = '{2'b01, 2'b10, 2'b11, 2'b00};

   fire_queue_if #(.DEPTH(4)) bus_if ();

   fire_queue #(
      .DEPTH         (4),
      .COOLDOWN      (16),
      .START_TIMEOUT (4)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bullet model: rises one cycle after a fire pulse, or is forced by hold.
   always @(posedge clk) begin
      #2;
      if (b_cnt > 0) b_cnt = b_cnt - 1;
      if (auto_bullet && fire_seen) b_cnt = b_len;
      fire_seen = bus_if.fire;
      bus_if.bullet_active = hold | (b_cnt > 0);
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_if.fire) begin
            fire_exp_t e;
            checks++;
            if (fire_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_fire: fire=1 orient=%0d at cycle %0d, required no fire", bus_if.orientation_out, cyc);
            end else begin
               e = fire_q.pop_front();
               if (bus_if.orientation_out !== e.orient || (e.cyc >= 0 && cyc != e.cyc)) begin
                  errors++;
                  $display("FAIL fire_event: orient=%0d cycle=%0d, required orient=%0d cycle=%0d",
                           bus_if.orientation_out, cyc, e.orient, e.cyc);
               end
            end
            checks++;
            if (bus_if.bullet_active !== 1'b0) begin
               errors++;
               $display("FAIL fire_while_active: bullet_active=%0b at cycle %0d, required 0", bus_if.bullet_active, cyc);
            end
            checks++;
            if (prev_fire) begin
               errors++;
               $display("FAIL fire_width: fire high two cycles at cycle %0d, required one-cycle pulse", cyc);
            end
         end
         if (bus_if.dropped) begin
            int d;
            checks++;
            if (drop_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_drop: dropped=1 at cycle %0d, required 0", cyc);
            end else begin
               d = drop_q.pop_front();
               if (cyc != d) begin
                  errors++;
                  $display("FAIL drop_cycle: dropped at cycle %0d, required cycle %0d", cyc, d);
               end
            end
         end
         prev_fire = bus_if.fire;
      end else begin
         prev_fire = 1'b0;
      end
   end

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, actual, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns two cycles later with the button released.
   task automatic press(input logic [1:0] o, output int pc);
      bus_if.orientation_in = orientation_t'(o);
      bus_if.btn_fire       = 1'b1;
      pc                    = cyc;
      step(2);
      bus_if.btn_fire       = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int pc;
      int pc2;
      int h;
      rst_n                 = 1'b0;
      hold                  = 1'b0;
      auto_bullet           = 1'b1;
      b_len                 = 5;
      bus_if.btn_fire       = 1'b0;
      bus_if.orientation_in = ORIENT_RIGHT;
      bus_if.bullet_active  = 1'b0;

      step(3);
      check("rst_fire",    int'(bus_if.fire), 0);
      check("rst_dropped", int'(bus_if.dropped), 0);
      check("rst_count",   int'(bus_if.count), 0);
      check("rst_empty",   int'(bus_if.empty), 1);
      check("rst_full",    int'(bus_if.full), 0);
      check("rst_orient",  int'(bus_if.orientation_out), 0);
      rst_n = 1'b1;
      step(2);

      // Single press, bullet idle: fire three cycles after the edge.
      press(2'b10, pc);
      fire_q.push_back('{2'b10, pc + 3});
      check("t1_count_after_push", int'(bus_if.count), 1);
      step(1);
      check("t1_count_after_pop", int'(bus_if.count), 0);
      check("t1_empty_after_pop", int'(bus_if.empty), 1);
      step(20);
      check("t1_orient_held", int'(bus_if.orientation_out), 2);

      // Fill with bullet busy, fifth press overflows, drain in order.
      hold = 1'b1;
      step(1);
      for (int i = 0; i < 5; i++) begin
         press(t2_orients[i], pc);
         if (i < 4) fire_q.push_back('{t2_orients[i], -1});
         else       drop_q.push_back(pc + 2);
         if (i == 3) begin
            check("t2_count_full", int'(bus_if.count), 4);
            check("t2_full_flag",  int'(bus_if.full), 1);
         end
         step(16);
      end
      check("t2_count_after_drop", int'(bus_if.count), 4);
      hold = 1'b0;
      step(60);
      check("t2_count_drained", int'(bus_if.count), 0);
      check("t2_empty_drained", int'(bus_if.empty), 1);

      // Second press inside cooldown is discarded without a drop.
      hold = 1'b1;
      step(1);
      press(2'b01, pc);
      fire_q.push_back('{2'b01, -1});
      step(3);
      press(2'b11, pc2);
      step(5);
      check("t3_count_rate_limited", int'(bus_if.count), 1);
      check("t3_press_spacing", pc2 - pc, 5);
      hold = 1'b0;
      step(30);
      check("t3_empty", int'(bus_if.empty), 1);

      // Bullet never starts: timeout after 4 cycles, next shot issues.
      auto_bullet = 1'b0;
      hold        = 1'b1;
      step(1);
      press(2'b11, pc);
      step(16);
      press(2'b01, pc);
      check("t4_count_two", int'(bus_if.count), 2);
      hold = 1'b0;
      h    = cyc;
      fire_q.push_back('{2'b11, h + 1});
      fire_q.push_back('{2'b01, h + 7});
      step(20);
      check("t4_count_drained", int'(bus_if.count), 0);

      // Reset mid-flight with three queued shots and the button held.
      auto_bullet = 1'b1;
      b_len       = 40;
      hold        = 1'b1;
      step(1);
      for (int i = 0; i < 4; i++) begin
         press(t5_orients[i], pc);
         if (i < 3) step(16);
      end
      check("t5_count_four", int'(bus_if.count), 4);
      hold = 1'b0;
      h    = cyc;
      fire_q.push_back('{2'b01, h + 1});
      step(5);
      check("t5_count_in_flight", int'(bus_if.count), 3);
      check("t5_bullet_active", int'(bus_if.bullet_active), 1);
      bus_if.btn_fire = 1'b1;
      rst_n           = 1'b0;
      #1;
      check("t5_rst_fire",    int'(bus_if.fire), 0);
      check("t5_rst_dropped", int'(bus_if.dropped), 0);
      check("t5_rst_count",   int'(bus_if.count), 0);
      check("t5_rst_empty",   int'(bus_if.empty), 1);
      check("t5_rst_full",    int'(bus_if.full), 0);
      check("t5_rst_orient",  int'(bus_if.orientation_out), 0);
      step(3);
      rst_n = 1'b1;
      step(20);
      check("t5_no_press_after_reset", int'(bus_if.count), 0);
      check("t5_empty_after_reset",    int'(bus_if.empty), 1);
      bus_if.btn_fire = 1'b0;
      step(5);

      check("pending_fires", fire_q.size(), 0);
      check("pending_drops", drop_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fire_queue.md
FIRE_QUEUE -- requirements
Module: fire_queue

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-002 Parameter COOLDOWN, default 16: minimum cycles between accepted shots; at least 1.
REQ-003 Parameter START_TIMEOUT, default 4: cycles to wait for bullet_active after issue.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-007 btn_fire  in  1  synchronized fire button level.
REQ-008 orientation_in  in  2  sprite orientation at press (00 right, 01 down, 10 left, 11 up).
REQ-009 bullet_active  in  1  bullet-in-flight flag from bullet_movement.
REQ-010 fire  out  1  one-cycle registered launch pulse to bullet_movement.
REQ-011 orientation_out  out  2  orientation of the current shot; held stable until the next issue.
REQ-012 count  out  $clog2(DEPTH)+1  queued shots.
REQ-013 full, empty  out  1 each  FIFO status, derived from registered count.
REQ-014 dropped  out  1  one-cycle pulse when a press is rejected.

Function
REQ-015 Press = rising edge of btn_fire (registered previous level); holding the button SHALL produce one press.
REQ-016 Cooldown counter SHALL load COOLDOWN-1 on each accepted push and decrement to 0, saturating at 0.
REQ-017 A press SHALL push orientation_in when cooldown==0 and full==0; otherwise dropped=1 on the next cycle.
REQ-018 Press during cooldown SHALL be discarded without dropped (rate limit, not overflow).
REQ-019 full SHALL gate the push from registered count; push is rejected when full even if a pop occurs the same cycle.
REQ-020 Push and pop in the same cycle (not full) SHALL leave count unchanged; FIFO order SHALL be preserved.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH.
REQ-022 Issue FSM states: IDLE, ISSUE, WAIT_START, IN_FLIGHT.
REQ-023 IDLE->ISSUE when empty==0 and bullet_active==0; pop the head and latch it into orientation_out.
REQ-024 ISSUE: fire=1 for exactly one cycle, then go to WAIT_START.
REQ-025 WAIT_START: when bullet_active==1, go to IN_FLIGHT; after START_TIMEOUT cycles without it, go to IDLE (shot lost, no retry).
REQ-026 IN_FLIGHT: when bullet_active==0, go to IDLE; the next issue is at least one cycle later.
REQ-027 fire SHALL never assert while bullet_active==1 or within the same shot's WAIT_START/IN_FLIGHT window.
REQ-028 Latency: a press into an empty FIFO with the bullet idle gives fire=1 three cycles after the btn_fire edge (edge detect, push, pop/latch, registered fire).

Reset
REQ-029 On reset=0, immediately: FSM=IDLE, pointers=0, count=0, empty=1, full=0, fire=0, dropped=0, orientation_out=00, cooldown=0, previous-level register=0.
REQ-030 Reset mid-flight SHALL discard all queued shots; btn_fire held through reset release SHALL NOT register a press.

Structure
REQ-031 The direction encoding (orientation_t) and the issue FSM state enum SHALL live in the shared game package, used also by bullet_movement.
REQ-032 The FIFO SHALL be one sub-module, shot_fifo (parameterized DEPTH, data width 2, push/pop/count/full/empty).
REQ-033 The edge detect, cooldown, and issue FSM SHALL stay in fire_queue.

Verification
REQ-034 Single press, orientation=10, bullet idle -> fire pulse 3 cycles later, orientation_out=10, count returns to 0.
REQ-035 5 presses spaced COOLDOWN+2 cycles, bullet_active held 1 -> count=4, full=1, fifth press gives dropped=1, shots issue in FIFO order after release.
REQ-036 2 presses 5 cycles apart (COOLDOWN=16) -> second press discarded, dropped=0, count=1.
REQ-037 fire issued, bullet_active never rises -> return to IDLE after 4 cycles, next queued shot issues.
REQ-038 Reset asserted with count=3 and FSM in IN_FLIGHT -> all outputs at reset values immediately; no fire after release while btn_fire held high.
